// File: rtl/caster_pkg.sv
// Shared types, width helpers and reset constants for the buffered PE data caster.
// Widths that depend on parameters are derived here so every file computes them the same way.
package caster_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_COL    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // A single-caster bus still needs a 1-bit tag field.
    function automatic int id_w(input int num_col);
        return (num_col > 1) ? $clog2(num_col) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_ID_W = id_w(DEF_NUM_COL);

    typedef logic [DEF_ID_W-1:0]       id_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    localparam logic RST_BUS_READY = 1'b1;
    localparam logic RST_RES_VALID = 1'b0;
    localparam logic RST_CFG_ERR   = 1'b0;

endpackage

// File: rtl/caster_fifo.sv
// Show-ahead synchronous FIFO: the head is visible on dout_o whenever not empty.
// full_o/empty_o come from the registered count, so a same-cycle pop never frees a slot for a push.
module caster_fifo
    import caster_pkg::*;
#(
    parameter  int W     = DEF_DATA_WIDTH,
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Stale storage is masked so an empty FIFO always presents zero.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/caster_buffered.sv
// PE data caster: tag-matched bus words are buffered into the PE, and PE results are
// returned through a single register slice tagged with this caster's programmable ID.
module caster_buffered
    import caster_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int NUM_COL    = DEF_NUM_COL,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  bit BCAST_EN   = 1'b1,
    localparam int ID_W       = id_w(NUM_COL),
    localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_id_we,
    input  logic [ID_W-1:0]       cfg_id,
    input  logic                  caster_en,
    input  logic                  bus_valid,
    input  logic [ID_W-1:0]       bus_tag,
    input  logic                  bus_bcast,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_ready,
    output logic                  pe_valid,
    output logic [DATA_WIDTH-1:0] pe_data,
    input  logic                  pe_ready,
    input  logic                  pe_res_valid,
    input  logic [DATA_WIDTH-1:0] pe_res_data,
    output logic                  pe_res_ready,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [ID_W-1:0]       res_tag,
    input  logic                  res_ready,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  cfg_err
);

    logic [ID_W-1:0]       id_q,        id_d;
    logic                  cfg_err_q,   cfg_err_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
    logic [ID_W-1:0]       res_tag_q,   res_tag_d;

    logic match, push, pop, full, empty, load, id_ok;

    assign match     = caster_en & ((bus_tag == id_q) | (BCAST_EN & bus_bcast));
    assign push      = bus_valid & match & ~full;
    assign pop       = ~empty & pe_ready;
    // A caster that is not the target never holds the shared bus.
    assign bus_ready = ~match | ~full;
    assign pe_valid  = ~empty;

    caster_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus_data),
        .dout_o  (pe_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    // ID may only change with nothing in flight, so no word is ever matched against a stale ID.
    assign id_ok = empty & ~res_valid_q & ~push;

    always_comb begin
        id_d      = id_q;
        cfg_err_d = cfg_err_q;
        if (cfg_id_we) begin
            if (id_ok) id_d      = cfg_id;
            else       cfg_err_d = 1'b1;
        end
    end

    assign pe_res_ready = ~res_valid_q | res_ready;
    assign load         = pe_res_valid & pe_res_ready;

    // NOTE: every always_comb target gets a default first, so no latch is inferred.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        if (load) begin
            res_valid_d = 1'b1;
            res_data_d  = pe_res_data;
            res_tag_d   = id_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q        <= '0;
            cfg_err_q   <= RST_CFG_ERR;
            res_valid_q <= RST_RES_VALID;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            id_q        <= id_d;
            cfg_err_q   <= cfg_err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign cfg_err   = cfg_err_q;

endmodule
